// File: rtl/fetch_sequencer.sv
// Program-counter / fetch sequencer feeding instruction memory, with a 4-entry branch-target LUT.
// Optional macro PC_RELATIVE_EN: branch target = pc + LUT entry instead of the absolute LUT entry.
module fetch_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] LUT_INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            branch,
  input  logic [1:0]      how_high,
  input  logic            lut_we,
  input  logic [1:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid,
  output logic            done,
  output logic            pc_wrap,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            wrap_q, wrap_d;
  logic            done_q;
  logic [PC_W-1:0] lut_q [4];
  logic [PC_W-1:0] branch_target;

  // Target is read from the LUT before any same-edge write lands.
`ifdef PC_RELATIVE_EN
  always_comb branch_target = pc_q + lut_q[how_high];
`else
  always_comb branch_target = lut_q[how_high];
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_RUN;
          wrap_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch) begin
          pc_d = branch_target;
        end else begin
          pc_d = pc_q + PC_W'(1);
          if (&pc_q) wrap_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          wrap_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        wrap_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) lut_q[i] <= LUT_INIT;
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign pc          = pc_q;
  assign done        = done_q;
  assign pc_wrap     = wrap_q;
  assign instr_valid = (state_q == S_RUN) & ~stall & ~halt_req;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, checked against a behavioural model.
module tb_fetch_sequencer;
  localparam int              PC_W   = 10;
  localparam logic [PC_W-1:0] PC_MAX = '1;

  logic            clk;
  logic            reset;
  logic            start, halt_req, stall, branch, lut_we;
  logic [1:0]      how_high, lut_waddr;
  logic [PC_W-1:0] lut_wdata;
  logic [PC_W-1:0] pc;
  logic            instr_valid, done, pc_wrap;
  logic [1:0]      state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: running/finished flags, pc, wrap flag and LUT contents.
  bit              m_run, m_done, m_wrap;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_lut [4];
  string           phase;

  fetch_sequencer #(.PC_W(PC_W), .LUT_INIT('0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
    .branch(branch), .how_high(how_high), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc(pc), .instr_valid(instr_valid), .done(done),
    .pc_wrap(pc_wrap), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_wrap = 0; m_pc = '0;
    for (int i = 0; i < 4; i++) m_lut[i] = '0;
  endtask

  task automatic cycle(input bit st, input bit hr, input bit sl, input bit br,
                       input logic [1:0] hh, input bit we, input logic [1:0] wa,
                       input logic [PC_W-1:0] wd);
    logic [PC_W-1:0] tgt;
    @(negedge clk);
    start = st; halt_req = hr; stall = sl; branch = br; how_high = hh;
    lut_we = we; lut_waddr = wa; lut_wdata = wd;
    #1;
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_run && !sl && !hr});
`ifdef PC_RELATIVE_EN
    tgt = m_pc + m_lut[hh];
`else
    tgt = m_lut[hh];
`endif
    if (!m_run) begin
      if (st) begin m_run = 1; m_done = 0; m_pc = '0; m_wrap = 0; end
    end else if (hr) begin
      m_run = 0; m_done = 1;
    end else if (!sl) begin
      if (br) m_pc = tgt;
      else begin
        if (m_pc == PC_MAX) m_wrap = 1;
        m_pc = m_pc + 1'b1;
      end
    end
    if (we) m_lut[wa] = wd;
    @(posedge clk);
    #1;
    check("pc", {22'b0, pc}, {22'b0, m_pc});
    check("done", {31'b0, done}, {31'b0, m_done});
    check("pc_wrap", {31'b0, pc_wrap}, {31'b0, m_wrap});
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'd0, 0, 2'd0, '0);
  endtask

  task automatic restart();
    cycle(0, 1, 0, 0, 2'd0, 0, 2'd0, '0);
    cycle(1, 0, 0, 0, 2'd0, 0, 2'd0, '0);
  endtask

  initial begin
    int budget;
    phase = "reset";
    reset = 1'b1;
    start = 0; halt_req = 0; stall = 0; branch = 0; how_high = '0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    model_reset();
    #1;
    check("pc", {22'b0, pc}, 32'h0);
    check("done", {31'b0, done}, 32'h0);
    check("pc_wrap", {31'b0, pc_wrap}, 32'h0);
    check("instr_valid", {31'b0, instr_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    phase = "lut_load";
    cycle(0, 0, 0, 0, 2'd0, 1, 2'd2, 10'h040);
    cycle(0, 0, 0, 0, 2'd0, 1, 2'd1, 10'h3FE);

    phase = "t1_count";
    cycle(1, 0, 0, 0, 2'd0, 0, 2'd0, '0);
    check("pc0", {22'b0, pc}, 32'd0);
    plain(5);
    check("pc5", {22'b0, pc}, 32'd5);

    phase = "t2_branch";
    restart();
    plain(3);
    cycle(0, 0, 0, 1, 2'd2, 0, 2'd0, '0);
`ifdef PC_RELATIVE_EN
    check("target", {22'b0, pc}, 32'h043);
`else
    check("target", {22'b0, pc}, 32'h040);
`endif

    phase = "t3_neg";
    restart();
    plain(10);
    cycle(0, 0, 0, 1, 2'd1, 0, 2'd0, '0);
`ifdef PC_RELATIVE_EN
    check("target", {22'b0, pc}, 32'd8);
`else
    check("target", {22'b0, pc}, 32'h3FE);
`endif

    phase = "t4_stall";
    restart();
    plain(7);
    cycle(0, 0, 1, 1, 2'd2, 0, 2'd0, '0);
    check("held", {22'b0, pc}, 32'd7);
    cycle(0, 0, 0, 1, 2'd2, 0, 2'd0, '0);

    phase = "t5_halt";
    restart();
    plain(12);
    cycle(0, 1, 0, 1, 2'd2, 0, 2'd0, '0);
    check("pc_hold", {22'b0, pc}, 32'd12);
    check("done_hi", {31'b0, done}, 32'd1);
    plain(2);
    cycle(1, 0, 0, 0, 2'd0, 0, 2'd0, '0);
    check("pc_restart", {22'b0, pc}, 32'd0);
    check("done_lo", {31'b0, done}, 32'd0);

    phase = "rbw";
    plain(2);
    cycle(0, 0, 0, 1, 2'd2, 1, 2'd2, 10'h123);
    cycle(0, 0, 0, 1, 2'd2, 0, 2'd0, '0);

    phase = "t6_wrap";
    budget = 1100;
    while (m_pc != PC_MAX && budget > 0) begin
      plain(1);
      budget--;
    end
    check("reach_max", {31'b0, budget > 0}, 32'd1);
    plain(1);
    check("wrapped_pc", {22'b0, pc}, 32'd0);
    check("wrap_set", {31'b0, pc_wrap}, 32'd1);
    plain(3);

    phase = "t6_async_reset";
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("pc", {22'b0, pc}, 32'd0);
    check("pc_wrap", {31'b0, pc_wrap}, 32'd0);
    check("done", {31'b0, done}, 32'd0);
    check("instr_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 0, 0, 0, 2'd0, 0, 2'd0, '0);
    plain(2);
    cycle(0, 0, 0, 1, 2'd2, 0, 2'd0, '0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
            2'($urandom_range(0, 3)), PC_W'($urandom_range(0, 1023)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
